// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add multiplier: captures two operands, accumulates one
// partial product per cycle, then applies the sign fix and pulses Done.
module seq_shift_add_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic                 Mode,
    input  logic [WIDTH-1:0]     DataA,
    input  logic [WIDTH-1:0]     DataB,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     ma_r;
    logic [WIDTH-1:0]     mb_r;
    logic                 neg_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 zero_r;
    logic [2*WIDTH-1:0]   product_r;

    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [2*WIDTH-1:0]   partial_s;
    logic [2*WIDTH-1:0]   result_s;
    logic                 last_s;

    // A negative signed operand becomes its WIDTH-bit unsigned magnitude, so -2^(W-1) maps to 2^(W-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    // Operand magnitudes, current partial product and sign-corrected result.
    always_comb begin
        mag_a_s   = magnitude(DataA, Mode);
        mag_b_s   = magnitude(DataB, Mode);
        partial_s = {{WIDTH{1'b0}}, ma_r} << count_r;
        last_s    = (count_r == CNT_W'(WIDTH - 1));
        if (neg_r) begin
            result_s = {(2*WIDTH){1'b0}} - acc_r;
        end else begin
            result_s = acc_r;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_r   <= '0;
            acc_r     <= '0;
            ma_r      <= '0;
            mb_r      <= '0;
            neg_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            zero_r    <= 1'b0;
            product_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        ma_r    <= mag_a_s;
                        mb_r    <= mag_b_s;
                        neg_r   <= Mode & (DataA[WIDTH-1] ^ DataB[WIDTH-1]);
                        acc_r   <= '0;
                        count_r <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                CALC: begin
                    if (mb_r[0]) begin
                        acc_r <= acc_r + partial_s;
                    end
                    mb_r    <= mb_r >> 1;
                    count_r <= count_r + CNT_W'(1);
                end
                FIX: begin
                    product_r <= result_s;
                    zero_r    <= (result_s == {(2*WIDTH){1'b0}});
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Product = product_r;
    assign Zero    = zero_r;

endmodule
